uart_tx_frame: RTL
==================

# uart_tx_frame

Synthesizable UART transmitter with a 16-byte transmit buffer, programmable parity and stop-bit count. It serves as the stimulus source on the top-level UART receive pin (ck_io8), the counterpart of the RX monitor that decodes ck_io7. It also serves as a drop-in TX peripheral for the core. Bytes enter through a valid/ready handshake, are queued, and are serialized LSB-first with no idle gap between queued frames.

## Interface
- CLKS_PER_BIT, default 868: uart_clk cycles per bit (100 MHz / 115200); legal range 1..65535.
- FIFO_DEPTH, default 16: byte slots in the transmit buffer; power of two.
- uart_clk  in  1  block clock, all logic on posedge.
- nrst  in  1  reset, synchronous, active-low.
- in_data  in  8  byte to transmit.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  equals !fifo_full; a byte is accepted on an edge where in_valid && in_ready.
- parity_sel  in  2  00 none, 01 even, 10 odd, 11 none.
- stop_sel  in  1  0 one stop bit, 1 two stop bits.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high while a frame is on the line (START through last STOP cycle).
- fifo_count  out  5  bytes queued, 0..FIFO_DEPTH.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.

## Operation
- Reset values: tx=1, tx_busy=0, in_ready=1, fifo_count=0, frame_done=0, FSM=IDLE, FIFO pointers cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE, FIFO non-empty: pop the head into shift_reg, latch parity_sel/stop_sel into frame config, load bit_cnt=CLKS_PER_BIT-1, go START. tx=0 from the same edge.
- Each state holds its tx value for exactly CLKS_PER_BIT cycles. A bit ends when bit_cnt==0, and bit_cnt then reloads.
- DATA: 8 bits, shift_reg[0] first, shift right each bit; data_idx 0..7. After bit 7, go PARITY if latched parity is enabled, else STOP.
- PARITY: tx = ^byte for even, ~^byte for odd.
- STOP: tx=1 for 1 or 2 bit times per latched stop_sel. On its final cycle, frame_done=1. Then:
  - FIFO non-empty: pop and go START directly (back-to-back, no idle cycle).
  - FIFO empty: go IDLE.
- Config changes mid-frame do not affect the current frame.
- Frame length = (10 + P + S2) * CLKS_PER_BIT cycles, where P = parity enabled and S2 = two stop bits.
- FIFO: a push and a pop on the same edge leave the count unchanged. in_ready does not anticipate a same-cycle pop; when full, a push is refused even if a pop occurs. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: on the next edge tx=1, the FIFO is emptied and the FSM is IDLE. The partial frame is abandoned.

## Timing
- Latency: a byte accepted at edge N with the block idle and the FIFO empty drives tx low at edge N+1.
- Pop happens at edge N+1; fifo_count reads 1 after N and 0 after N+1.
- tx and tx_busy are registered outputs with no combinational path from inputs. in_ready depends only on registered count.
- With CLKS_PER_BIT=1, each state lasts one cycle, so uart_clk may be the bit clock itself.

## Structure
- Shared package uart_pkg:
  - typedef enum of FSM states.
  - PARITY_NONE/EVEN/ODD localparams.
  - Stop-select encodings.
  - Shared with the existing RX decode logic.
- Sub-module uart_tx_fifo: synchronous FIFO, single clock, with push/pop/full/empty/count, parameterized width and depth. The top module holds the FSM, bit counter and shift register.

## Test plan
- CLKS_PER_BIT=4, push 0x55, no parity, 1 stop -> tx per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1; frame_done pulses once at cycle 40 after start; tx_busy high for 40 cycles.
- Push 0x03 with even parity, then 0x03 with odd parity, 2 stops -> parity bits 0 then 1; each frame is 48 cycles; the second START immediately follows the first STOP (no gap).
- From idle, assert in_valid continuously with bytes 0x00..0x11 -> 17 bytes accepted (first popped at edge 2), in_ready low with fifo_count=16, 18th byte stalls until the first frame_done; all bytes emerge in order.
- Change parity_sel from none to odd during DATA of frame 1 -> frame 1 has no parity bit; frame 2 carries an odd parity bit.
- Drop nrst during DATA bit 3 -> next edge tx=1, fifo_count=0, tx_busy=0; after release, a new push yields a clean frame with correct latency.
- CLKS_PER_BIT=1, push 0xA5, odd parity -> 11-cycle frame with bit sequence 0,1,0,1,0,0,1,0,1,1,1 (parity 1).

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared UART definitions used by the TX framer and by the RX decode logic.
// It holds the frame FSM state encoding, the parity_sel encodings, the
// stop_sel encodings and the parity helpers. Both sides of the link use the
// same helpers, so they always agree on the parity convention.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // parity_sel encodings; 2'b11 is a second "none" code.
  localparam logic [1:0] PARITY_NONE     = 2'b00;
  localparam logic [1:0] PARITY_EVEN     = 2'b01;
  localparam logic [1:0] PARITY_ODD      = 2'b10;
  localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

  // stop_sel encodings.
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // True when the selected mode inserts a parity bit into the frame.
  function automatic logic parity_enabled(input logic [1:0] sel);
    case (sel)
      PARITY_EVEN,
      PARITY_ODD: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Parity bit for a data byte. Even parity gives ^data and odd parity gives ~^data.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] sel);
    case (sel)
      PARITY_ODD: return ~^data;
      default:    return ^data;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Single-clock synchronous FIFO with registered pointers and a registered
// occupancy count. DEPTH must be a power of two so that the pointers wrap
// naturally.
// Ports:
//   clk, nrst            clock; synchronous active-low reset (empties the FIFO)
//   push, wr_data        write request and data; ignored while full
//   pop, rd_data         read request and the current head; pop ignored while empty
//   full, empty, count   status derived from the registered count
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Full is evaluated before any same-cycle pop, so a full FIFO refuses a push.
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write port (data needs no reset; validity is tracked by count_r).
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// UART transmitter with a byte FIFO. It sends frames LSB-first: a start bit,
// 8 data bits, an optional parity bit, then 1 or 2 stop bits. Queued bytes go
// out back-to-back with no idle cycle between frames.
// Ports:
//   uart_clk, nrst        clock; synchronous active-low reset
//   in_data/in_valid      byte offered by the producer
//   in_ready              !fifo_full; a byte is taken when in_valid && in_ready
//   parity_sel, stop_sel  frame format; sampled when a byte leaves the FIFO
//   tx                    serial line, idle high (registered)
//   tx_busy               high from the START bit through the last STOP cycle
//   fifo_count            bytes currently queued
//   frame_done            high on the last cycle of each frame's final stop bit
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       uart_clk,
  input  logic       nrst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] parity_sel,
  input  logic       stop_sel,
  output logic       tx,
  output logic       tx_busy,
  output logic [4:0] fifo_count,
  output logic       frame_done
);
  localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [7:0]       fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_cnt_s;
  logic             pop_s;
  logic             load_s;
  logic             bit_end_s;

  uart_state_t state_r, state_nx_s;
  logic [15:0] bit_cnt_r, bit_cnt_nx_s;
  logic [2:0]  data_idx_r, data_idx_nx_s;
  logic        stop_idx_r, stop_idx_nx_s;
  logic [7:0]  shift_r, shift_nx_s;
  logic        par_en_r, par_en_nx_s;
  logic        par_bit_r, par_bit_nx_s;
  logic        stop2_r, stop2_nx_s;
  logic        tx_r, tx_nx_s;
  logic        busy_r, busy_nx_s;
  logic        done_r, done_nx_s;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (uart_clk),
    .nrst    (nrst),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (pop_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_cnt_s)
  );

  assign in_ready   = !fifo_full_s;
  assign fifo_count = 5'(fifo_cnt_s);
  assign tx         = tx_r;
  assign tx_busy    = busy_r;
  assign frame_done = done_r;
  assign bit_end_s  = (bit_cnt_r == 16'd0);

  // Next-state, bit timing and next line value for the frame FSM.
  always_comb begin
    state_nx_s    = state_r;
    bit_cnt_nx_s  = bit_cnt_r;
    data_idx_nx_s = data_idx_r;
    stop_idx_nx_s = stop_idx_r;
    shift_nx_s    = shift_r;
    par_en_nx_s   = par_en_r;
    par_bit_nx_s  = par_bit_r;
    stop2_nx_s    = stop2_r;
    tx_nx_s       = tx_r;
    load_s        = 1'b0;
    pop_s         = 1'b0;

    case (state_r)
      ST_IDLE: begin
        tx_nx_s = 1'b1;
        if (!fifo_empty_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          bit_cnt_nx_s  = BIT_RELOAD;
          data_idx_nx_s = 3'd0;
          tx_nx_s       = shift_r[0];
          state_nx_s    = ST_DATA;
        end else begin
          bit_cnt_nx_s = bit_cnt_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          bit_cnt_nx_s = BIT_RELOAD;
          if (data_idx_r == 3'd7) begin
            if (par_en_r) begin
              state_nx_s = ST_PARITY;
              tx_nx_s    = par_bit_r;
            end else begin
              state_nx_s    = ST_STOP;
              stop_idx_nx_s = 1'b0;
              tx_nx_s       = 1'b1;
            end
          end else begin
            // The next bit is shift_r[1], which becomes bit 0 after this shift.
            data_idx_nx_s = data_idx_r + 3'd1;
            shift_nx_s    = {1'b0, shift_r[7:1]};
            tx_nx_s       = shift_r[1];
          end
        end else begin
          bit_cnt_nx_s = bit_cnt_r - 16'd1;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          bit_cnt_nx_s  = BIT_RELOAD;
          stop_idx_nx_s = 1'b0;
          state_nx_s    = ST_STOP;
          tx_nx_s       = 1'b1;
        end else begin
          bit_cnt_nx_s = bit_cnt_r - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (stop_idx_r || !stop2_r) begin
            if (!fifo_empty_s) begin
              load_s = 1'b1;
            end else begin
              state_nx_s = ST_IDLE;
              tx_nx_s    = 1'b1;
            end
          end else begin
            stop_idx_nx_s = 1'b1;
            bit_cnt_nx_s  = BIT_RELOAD;
          end
        end else begin
          bit_cnt_nx_s = bit_cnt_r - 16'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        tx_nx_s    = 1'b1;
      end
    endcase

    // Take the FIFO head and latch the frame format at pop time. This keeps
    // later pin changes out of the frame that is already on the line.
    if (load_s) begin
      pop_s         = 1'b1;
      shift_nx_s    = fifo_head_s;
      par_en_nx_s   = parity_enabled(parity_sel);
      par_bit_nx_s  = parity_bit(fifo_head_s, parity_sel);
      stop2_nx_s    = (stop_sel == STOP_TWO);
      bit_cnt_nx_s  = BIT_RELOAD;
      data_idx_nx_s = 3'd0;
      stop_idx_nx_s = 1'b0;
      state_nx_s    = ST_START;
      tx_nx_s       = 1'b0;
    end else begin
      pop_s = 1'b0;
    end

    busy_nx_s = (state_nx_s != ST_IDLE);
    // Registered decode of "the next cycle is the final stop cycle". It also
    // covers CLKS_PER_BIT=1, where that cycle is the one entering the bit.
    done_nx_s = (state_nx_s == ST_STOP) && (bit_cnt_nx_s == 16'd0) &&
                (stop_idx_nx_s || !stop2_nx_s);
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 16'd0;
      data_idx_r <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= 8'd0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      stop2_r    <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      bit_cnt_r  <= bit_cnt_nx_s;
      data_idx_r <= data_idx_nx_s;
      stop_idx_r <= stop_idx_nx_s;
      shift_r    <= shift_nx_s;
      par_en_r   <= par_en_nx_s;
      par_bit_r  <= par_bit_nx_s;
      stop2_r    <= stop2_nx_s;
      tx_r       <= tx_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
    end
  end

endmodule
